// File: rtl/ahb_slave_fifo.sv
// AHB-Lite slave front end for the AHB-to-APB bridge: decodes its address window,
// runs the data-phase FSM and queues posted writes and read commands toward APB.
module ahb_slave_fifo #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hA000_0000,
    parameter int                WIN_LOG2  = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HBURST,
    input  logic [1:0]        HTRANS,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_write,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WDATA = 3'd1;
    localparam logic [2:0] S_RWAIT = 3'd2;
    localparam logic [2:0] S_RDONE = 3'd3;
    localparam logic [2:0] S_ERR1  = 3'd4;
    localparam logic [2:0] S_ERR2  = 3'd5;

    localparam logic [ADDR_W-1:0] WIN_MASK = {ADDR_W{1'b1}} << WIN_LOG2;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_pushed_q, rd_pushed_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic              mem_write [DEPTH];
    logic [DATA_W-1:0] mem_wdata [DEPTH];

    logic              full, pop, push, push_write, accept, in_win;
    logic [DATA_W-1:0] push_data;
    logic [2:0]        accept_state;

    // Burst type and the BUSY/IDLE distinction carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0]};

    assign full      = (count_q == CNT_W'(DEPTH));
    assign cmd_valid = (count_q != '0);
    assign pop       = cmd_valid & cmd_ready;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            S_WDATA: HREADYOUT = ~full;
            S_RWAIT: HREADYOUT = 1'b0;
            S_ERR1:  begin HREADYOUT = 1'b0; HRESP = 1'b1; end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
    end

    // A new address phase is only taken while our own data phase is completing.
    assign accept       = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign in_win       = ((HADDR & WIN_MASK) == BASE_ADDR);
    assign accept_state = !in_win ? S_ERR1 : (HWRITE ? S_WDATA : S_RWAIT);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_pushed_d = rd_pushed_q;
        hrdata_d    = hrdata_q;
        push        = 1'b0;
        push_write  = 1'b0;
        push_data   = '0;
        case (state_q)
            S_WDATA: begin
                if (!full) begin
                    push       = 1'b1;
                    push_write = 1'b1;
                    push_data  = HWDATA;
                    state_d    = S_IDLE;
                end
            end
            S_RWAIT: begin
                if (!rd_pushed_q && !full) begin
                    push        = 1'b1;
                    rd_pushed_d = 1'b1;
                end
                if (rd_valid) begin
                    hrdata_d = rd_data;
                    state_d  = S_RDONE;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d     = accept_state;
            addr_d      = HADDR;
            rd_pushed_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rd_pushed_q <= 1'b0;
            hrdata_q    <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_pushed_q <= rd_pushed_d;
            hrdata_q    <= hrdata_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array has no reset; empty entries are masked at the outputs instead.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_addr[wptr_q]  <= addr_q;
            mem_write[wptr_q] <= push_write;
            mem_wdata[wptr_q] <= push_data;
        end
    end

    assign cmd_addr  = cmd_valid ? mem_addr[rptr_q]  : '0;
    assign cmd_write = cmd_valid ? mem_write[rptr_q] : 1'b0;
    assign cmd_wdata = cmd_valid ? mem_wdata[rptr_q] : '0;
    assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_fifo.sv
// Self-checking bench for ahb_slave_fifo: directed scenarios plus random AHB
// traffic checked against a queue-based transaction model.
module tb_ahb_slave_fifo;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } cmd_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic        cmd_valid, cmd_ready, cmd_write, rd_valid;
    logic [31:0] cmd_addr, cmd_wdata, rd_data;

    int n_checks = 0;
    int n_errors = 0;

    cmd_t        exp_q[$];
    logic [31:0] exp_rd[$];

    logic [31:0] x_addr [64];
    logic        x_write[64];
    logic [31:0] x_wdata[64];
    int          r_waits[64];
    logic        r_resp_first[64];
    logic [31:0] r_rdata[64];
    bit          master_done;

    bit          resp_en = 1'b0;
    bit          resp_rand = 1'b0;
    bit          rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed_val = '0;
    int          rd_lat = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_pending = '0;

    // Single-slave bus: the bus-wide ready is this slave's ready.
    assign HREADY = HREADYOUT;

    ahb_slave_fifo dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a & ~((32'd1 << 16) - 32'd1)) == 32'hA000_0000;
    endfunction

    // Compare the FIFO head against the oldest outstanding modelled command.
    task automatic check_pop();
        cmd_t e;
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check("pop_addr", cmd_addr, e.addr);
        check("pop_write", cmd_write, e.wr);
        check("pop_wdata", cmd_wdata, e.wdata);
    endtask

    // Pipelined AHB master: runs x_*[0..n-1] back to back, called at a negedge.
    task automatic ahb_run(input int n);
        int a = 0;
        int d = -1;
        int cyc = 0;
        bit fresh = 1'b0;
        master_done = 1'b0;
        while ((a < n || d >= 0) && cyc < 400) begin
            cyc++;
            if (a < n) begin
                HSEL = 1'b1; HTRANS = (a == 0) ? 2'b10 : 2'b11;
                HADDR = x_addr[a]; HWRITE = x_write[a];
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
            end
            HWDATA = (d >= 0 && x_write[d]) ? x_wdata[d] : '0;
            if (d >= 0 && fresh) begin
                r_resp_first[d] = HRESP;
                fresh = 1'b0;
            end
            if (HREADYOUT) begin
                if (d >= 0) begin
                    r_rdata[d] = HRDATA;
                    if (in_window(x_addr[d])) begin
                        check("resp_okay", HRESP, 1'b0);
                        if (!x_write[d])
                            check("read_data", HRDATA, (exp_rd.size() != 0) ? exp_rd.pop_front() : 'x);
                    end else begin
                        check("err_waits", r_waits[d], 1);
                        check("err_resp_first", r_resp_first[d], 1'b1);
                        check("err_resp_last", HRESP, 1'b1);
                    end
                end
                if (a < n) begin
                    if (in_window(x_addr[a]))
                        exp_q.push_back('{x_addr[a], x_write[a], x_write[a] ? x_wdata[a] : 32'h0});
                    d = a; a++; r_waits[d] = 0; fresh = 1'b1;
                end else begin
                    d = -1;
                end
            end else if (d >= 0) begin
                r_waits[d]++;
            end
            @(posedge HCLK);
            @(negedge HCLK);
        end
        check("master_complete", (a >= n && d < 0), 1'b1);
        HSEL = 1'b0; HTRANS = 2'b00;
        master_done = 1'b1;
    endtask

    // Let the downstream side pop until the model is empty, then confirm the FIFO is too.
    task automatic drain(input bit rnd);
        int cyc = 0;
        resp_rand = rnd;
        resp_en = 1'b1;
        while ((exp_q.size() != 0 || rd_cnt != 0) && cyc < 300) begin
            @(negedge HCLK);
            cyc++;
        end
        @(negedge HCLK);
        check("drain_model_empty", exp_q.size(), 0);
        check("drain_cmd_valid", cmd_valid, 1'b0);
        resp_en = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
    endtask

    // Downstream APB side: pops the head and returns read data after a latency.
    initial begin
        forever begin
            @(negedge HCLK);
            if (resp_en) begin
                rd_valid = 1'b0;
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin rd_valid = 1'b1; rd_data = rd_pending; end
                end
                cmd_ready = resp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (cmd_valid && cmd_ready) begin
                    if (!cmd_write) begin
                        rd_pending = rd_fixed_en ? rd_fixed_val : $urandom;
                        exp_rd.push_back(rd_pending);
                        rd_cnt = (rd_lat != 0) ? rd_lat : int'($urandom_range(1, 4));
                    end
                    check_pop();
                end
            end
        end
    end

    initial begin
        int cyc;
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HBURST = 3'b001;
        HTRANS = 2'b00; HWDATA = '0; cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        #1;
        check("rst_hreadyout", HREADYOUT, 1'b1);
        check("rst_hresp", HRESP, 1'b0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_addr", cmd_addr, 32'h0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // IDLE and BUSY with HSEL asserted: nothing accepted.
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'hA000_0000; HWRITE = 1'b1;
        @(negedge HCLK);
        check("idle_ready", HREADYOUT, 1'b1);
        check("idle_resp", HRESP, 1'b0);
        HTRANS = 2'b01;
        @(negedge HCLK);
        @(negedge HCLK);
        check("busy_ready", HREADYOUT, 1'b1);
        check("busy_resp", HRESP, 1'b0);
        check("busy_cmd_valid", cmd_valid, 1'b0);
        HSEL = 1'b0; HTRANS = 2'b00;

        // Two back-to-back writes with no downstream pops.
        x_addr[0] = 32'hA000_0000; x_write[0] = 1'b1; x_wdata[0] = 32'h1234_5678;
        x_addr[1] = 32'hA000_0004; x_write[1] = 1'b1; x_wdata[1] = 32'h5678_1234;
        ahb_run(2);
        check("wr0_waits", r_waits[0], 0);
        check("wr1_waits", r_waits[1], 0);
        check("wr_head_valid", cmd_valid, 1'b1);
        check("wr_head_addr", cmd_addr, 32'hA000_0000);
        check("wr_head_data", cmd_wdata, 32'h1234_5678);
        drain(1'b0);

        // DEPTH+1 writes: the last data phase stalls until a pop frees space.
        for (int i = 0; i < 5; i++) begin
            x_addr[i] = 32'hA000_0100 + 32'(i * 4); x_write[i] = 1'b1; x_wdata[i] = $urandom;
        end
        fork ahb_run(5); join_none
        cyc = 0;
        while (HREADYOUT !== 1'b0 && cyc < 20) begin @(negedge HCLK); cyc++; end
        check("full_stall", HREADYOUT, 1'b0);
        check("full_model_entries", exp_q.size(), 5);
        check("full_prev_waits", r_waits[3], 0);
        @(negedge HCLK);
        check("full_stall_hold", HREADYOUT, 1'b0);
        check_pop();
        cmd_ready = 1'b1;
        check("full_pop_cycle_ready", HREADYOUT, 1'b0);
        @(negedge HCLK);
        cmd_ready = 1'b0;
        check("full_release_ready", HREADYOUT, 1'b1);
        cyc = 0;
        while (!master_done && cyc < 20) begin @(negedge HCLK); cyc++; end
        check("full_master_done", master_done, 1'b1);
        check("full_refill_valid", cmd_valid, 1'b1);
        check("full_model_depth", exp_q.size(), 4);
        drain(1'b0);

        // Read behind two queued writes; data returned three cycles after its pop.
        x_addr[0] = 32'hA000_0010; x_write[0] = 1'b1; x_wdata[0] = 32'h1111_2222;
        x_addr[1] = 32'hA000_0014; x_write[1] = 1'b1; x_wdata[1] = 32'h3333_4444;
        ahb_run(2);
        x_addr[0] = 32'hA000_0008; x_write[0] = 1'b0; x_wdata[0] = '0;
        rd_fixed_en = 1'b1; rd_fixed_val = 32'hABCD_EF01; rd_lat = 3; resp_rand = 1'b0;
        fork ahb_run(1); join_none
        repeat (2) @(negedge HCLK);
        resp_en = 1'b1;
        cyc = 0;
        while (!master_done && cyc < 40) begin @(negedge HCLK); cyc++; end
        check("rd_master_done", master_done, 1'b1);
        check("rd_hrdata", r_rdata[0], 32'hABCD_EF01);
        check("rd_min_waits", (r_waits[0] >= 2), 1'b1);
        drain(1'b0);
        rd_fixed_en = 1'b0; rd_lat = 0;

        // Out-of-window write: two-cycle ERROR, no FIFO push.
        x_addr[0] = 32'hB000_0000; x_write[0] = 1'b1; x_wdata[0] = 32'h5555_AAAA;
        ahb_run(1);
        check("err_no_push", cmd_valid, 1'b0);

        // Reset in the middle of a read wait with three entries queued.
        x_addr[0] = 32'hA000_0020; x_write[0] = 1'b1; x_wdata[0] = 32'h0000_0020;
        x_addr[1] = 32'hA000_0024; x_write[1] = 1'b1; x_wdata[1] = 32'h0000_0024;
        ahb_run(2);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'hA000_0030; HWRITE = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        check("rst_rwait_ready", HREADYOUT, 1'b0);
        @(negedge HCLK);
        check("rst_rwait_valid", cmd_valid, 1'b1);
        HRESETn = 1'b0;
        #1;
        exp_q.delete();
        check("rst_mid_ready", HREADYOUT, 1'b1);
        check("rst_mid_resp", HRESP, 1'b0);
        check("rst_mid_valid", cmd_valid, 1'b0);
        check("rst_mid_addr", cmd_addr, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
        @(negedge HCLK);
        rd_valid = 1'b0;
        check("rst_late_rd_ready", HREADYOUT, 1'b1);
        check("rst_late_rd_hrdata", HRDATA, 32'h0);
        check("rst_late_rd_valid", cmd_valid, 1'b0);

        // Random mixed traffic against the transaction model.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 12; i++) begin
                x_write[i] = 1'($urandom_range(0, 1));
                x_wdata[i] = $urandom;
                if ($urandom_range(0, 7) == 0) x_addr[i] = 32'hB000_0000 | ($urandom & 32'h0000_FFFC);
                else                           x_addr[i] = 32'hA000_0000 | ($urandom & 32'h0000_FFFC);
            end
            resp_rand = 1'b1;
            resp_en = 1'b1;
            ahb_run(12);
            drain(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_fifo.md
# ahb_slave_fifo

Parametrised AHB-Lite slave front end for the AHB-to-APB bridge. Decodes its address window, pipelines AHB address and data phases, and buffers posted writes and read commands in a DEPTH-entry FIFO toward the APB master side. Adds features the single-register slave lacks: back-pressure via HREADYOUT, read-data return, and ERROR responses for out-of-window accesses.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 4, command FIFO entries; power of two, ≥2
- BASE_ADDR, 32'hA000_0000, window base; aligned to window size
- WIN_LOG2, 16, window size is 2^WIN_LOG2 bytes

Ports:
- HCLK  in  1  single clock; all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  address-phase address
- HWRITE  in  1  1 = write
- HBURST  in  3  burst type; accepted, not checked
- HTRANS  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
- HREADY  in  1  bus-wide ready (previous data phase complete)
- HWDATA  in  DATA_W  write data, valid in data phase
- HRDATA  out  DATA_W  read data, registered
- HREADYOUT  out  1  this slave's data-phase ready
- HRESP  out  1  0 OKAY, 1 ERROR
- cmd_valid  out  1  FIFO non-empty
- cmd_ready  in  1  downstream pops the head entry
- cmd_addr  out  ADDR_W  head address
- cmd_write  out  1  head direction
- cmd_wdata  out  DATA_W  head write data (0 for reads)
- rd_valid  in  1  one-cycle pulse: read data returned
- rd_data  in  DATA_W  returned read data

## Operation
- Transfer accepted on an edge where HSEL & HREADY & HTRANS[1]; HADDR, HWRITE latched; data-phase FSM entered next cycle. IDLE/BUSY or HSEL=0: nothing latched, OKAY.
- In window: (HADDR & ~(2^WIN_LOG2-1)) == BASE_ADDR.
- FSM states: IDLE, WDATA, RWAIT, RDONE, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. Accepted transfer: out-of-window -> ERR1; write -> WDATA; read -> RWAIT.
- WDATA: if not full, push {addr,1,HWDATA}, HREADYOUT=1, then go to IDLE or to the next accepted transfer's state (back-to-back). If full, HREADYOUT=0; stay; retry each cycle.
- RWAIT: push {addr,0,0} on the first cycle FIFO is not full; HREADYOUT=0 throughout. rd_valid -> load HRDATA <= rd_data, go to RDONE. rd_valid is ignored in every other state.
- RDONE: HREADYOUT=1, HRESP=0; accept next transfer as in IDLE.
- ERR1: HREADYOUT=0, HRESP=1, no push -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1; may accept next transfer.
- FIFO: pop when cmd_valid & cmd_ready. count is (log2(DEPTH)+1) bits; pointers wrap modulo DEPTH. cmd_* show the head; all zero when empty.
- Full is evaluated before the same-cycle pop. A push while full is refused even if a pop occurs that cycle. Push and pop together when 0<count<DEPTH leaves count unchanged.
- Order is strict: a read is issued only behind all earlier posted writes.

## Timing
- Reset (async assert, sync-clean release): state IDLE, count 0, HREADYOUT=1, HRESP=0, HRDATA=0, cmd_valid=0, cmd_addr/cmd_write/cmd_wdata=0. Reset mid-transfer discards FIFO contents and any pending read.
- Write: address at edge N, data phase N+1, zero wait states if not full. cmd_valid rises at N+2 when FIFO was empty.
- Read: push at N+1 (if not full). HREADYOUT stays 0 until the cycle after rd_valid. Minimum 2 wait states.
- Error: exactly two cycles (ERR1, ERR2), HRESP high in both.
- HREADYOUT is combinational from state and full only, never from HTRANS/HADDR.
- HRDATA holds its value until the next rd_valid.

## Test plan
- Reset, then IDLE/BUSY with HSEL=1 -> HREADYOUT=1, HRESP=0, cmd_valid=0, count 0.
- NONSEQ write A000_0000/1234_5678, then SEQ write A000_0004/5678_1234, cmd_ready=0 -> zero wait states; two entries in order at head once cmd_ready=1.
- DEPTH+1 back-to-back writes, cmd_ready=0 -> last data phase HREADYOUT=0. Single pop releases it; count returns to DEPTH. Pop and push in the same full cycle -> push refused.
- Read A000_0008 behind 2 queued writes; rd_valid with ABCD_EF01 three cycles after read pops -> HREADYOUT=1 the next cycle, HRDATA=ABCD_EF01.
- Write to B000_0000 -> ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1), no FIFO push.
- HRESETn low mid-RWAIT with 3 entries -> immediate IDLE, cmd_valid=0, HREADYOUT=1. A later rd_valid is ignored.
